// File: rtl/s_ctrl_m.sv
// Single-cycle MIPS-style main control decoder with registered outputs.
// Opcode/function/zero are decoded combinationally and captured every rising clk edge.
module s_ctrl_m (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OPcode,
  input  logic [5:0] Fun,
  input  logic       MIO_ready,
  input  logic       zero,
  output logic       RegDst,
  output logic       ALUSrc_B,
  output logic [1:0] DatatoReg,
  output logic       Jal,
  output logic [1:0] Branch,
  output logic       RegWrite,
  output logic       mem_w,
  output logic [2:0] ALU_Control,
  output logic       CPU_MIO
);

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluXor = 3'b011;
  localparam logic [2:0] AluNor = 3'b100;
  localparam logic [2:0] AluSrl = 3'b101;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  logic       regDst_d, regDst_q;
  logic       aluSrcB_d, aluSrcB_q;
  logic [1:0] datatoReg_d, datatoReg_q;
  logic       jal_d, jal_q;
  logic [1:0] branch_d, branch_q;
  logic       regWrite_d, regWrite_q;
  logic       memW_d, memW_q;
  logic [2:0] aluCtrl_d, aluCtrl_q;
  logic       cpuMio_d, cpuMio_q;

  // MIO_ready is intentionally unused: this controller never stalls.
  logic unusedReady;
  assign unusedReady = MIO_ready;

  always_comb begin
    regDst_d    = 1'b0;
    aluSrcB_d   = 1'b0;
    datatoReg_d = 2'b00;
    jal_d       = 1'b0;
    branch_d    = 2'b00;
    regWrite_d  = 1'b0;
    memW_d      = 1'b0;
    aluCtrl_d   = AluAdd;
    cpuMio_d    = 1'b0;

    case (OPcode)
      6'b000000: begin
        regDst_d   = 1'b1;
        regWrite_d = 1'b1;
        case (Fun)
          6'b100000: aluCtrl_d = AluAdd;
          6'b100010: aluCtrl_d = AluSub;
          6'b100100: aluCtrl_d = AluAnd;
          6'b100101: aluCtrl_d = AluOr;
          6'b101010: aluCtrl_d = AluSlt;
          6'b100111: aluCtrl_d = AluNor;
          6'b000010: aluCtrl_d = AluSrl;
          6'b100110,
          6'b010110: aluCtrl_d = AluXor;
          6'b001000: begin
            branch_d   = 2'b11;
            regWrite_d = 1'b0;
            regDst_d   = 1'b0;
          end
          // Unknown function codes become a no-op rather than a stray write.
          default: begin
            regWrite_d = 1'b0;
            regDst_d   = 1'b0;
          end
        endcase
      end
      6'b100011: begin
        aluSrcB_d   = 1'b1;
        datatoReg_d = 2'b01;
        regWrite_d  = 1'b1;
        cpuMio_d    = 1'b1;
      end
      6'b101011: begin
        aluSrcB_d = 1'b1;
        memW_d    = 1'b1;
        cpuMio_d  = 1'b1;
      end
      6'b000100: begin
        aluCtrl_d = AluSub;
        branch_d  = zero ? 2'b01 : 2'b00;
      end
      6'b000101: begin
        aluCtrl_d = AluSub;
        branch_d  = zero ? 2'b00 : 2'b01;
      end
      6'b000010: branch_d = 2'b10;
      6'b000011: begin
        branch_d    = 2'b10;
        jal_d       = 1'b1;
        regWrite_d  = 1'b1;
        datatoReg_d = 2'b10;
      end
      6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: begin
        aluSrcB_d  = 1'b1;
        regWrite_d = 1'b1;
        case (OPcode[2:0])
          3'b010:  aluCtrl_d = AluSlt;
          3'b100:  aluCtrl_d = AluAnd;
          3'b101:  aluCtrl_d = AluOr;
          3'b110:  aluCtrl_d = AluXor;
          default: aluCtrl_d = AluAdd;
        endcase
      end
      6'b001111: begin
        aluSrcB_d   = 1'b1;
        regWrite_d  = 1'b1;
        datatoReg_d = 2'b11;
      end
      default: ;
    endcase
  end

  // Reset clears everything, including ALU_Control, which differs from the decode default.
  always_ff @(posedge clk) begin
    if (rst) begin
      regDst_q    <= 1'b0;
      aluSrcB_q   <= 1'b0;
      datatoReg_q <= 2'b00;
      jal_q       <= 1'b0;
      branch_q    <= 2'b00;
      regWrite_q  <= 1'b0;
      memW_q      <= 1'b0;
      aluCtrl_q   <= 3'b000;
      cpuMio_q    <= 1'b0;
    end else begin
      regDst_q    <= regDst_d;
      aluSrcB_q   <= aluSrcB_d;
      datatoReg_q <= datatoReg_d;
      jal_q       <= jal_d;
      branch_q    <= branch_d;
      regWrite_q  <= regWrite_d;
      memW_q      <= memW_d;
      aluCtrl_q   <= aluCtrl_d;
      cpuMio_q    <= cpuMio_d;
    end
  end

  assign RegDst      = regDst_q;
  assign ALUSrc_B    = aluSrcB_q;
  assign DatatoReg   = datatoReg_q;
  assign Jal         = jal_q;
  assign Branch      = branch_q;
  assign RegWrite    = regWrite_q;
  assign mem_w       = memW_q;
  assign ALU_Control = aluCtrl_q;
  assign CPU_MIO     = cpuMio_q;

endmodule

// File: tb/tb_s_ctrl_m.sv
// Bench for s_ctrl_m: table-driven instruction model checked every cycle,
// plus directed vectors with hand-written expected output words.
module tb_s_ctrl_m;

  logic       clk;
  logic       rst;
  logic [5:0] OPcode;
  logic [5:0] Fun;
  logic       MIO_ready;
  logic       zero;
  logic       RegDst;
  logic       ALUSrc_B;
  logic [1:0] DatatoReg;
  logic       Jal;
  logic [1:0] Branch;
  logic       RegWrite;
  logic       mem_w;
  logic [2:0] ALU_Control;
  logic       CPU_MIO;

  int total = 0;
  int bad   = 0;

  s_ctrl_m dut (
    .clk(clk), .rst(rst), .OPcode(OPcode), .Fun(Fun), .MIO_ready(MIO_ready),
    .zero(zero), .RegDst(RegDst), .ALUSrc_B(ALUSrc_B), .DatatoReg(DatatoReg),
    .Jal(Jal), .Branch(Branch), .RegWrite(RegWrite), .mem_w(mem_w),
    .ALU_Control(ALU_Control), .CPU_MIO(CPU_MIO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output word: {RegDst, ALUSrc_B, DatatoReg, Jal, Branch, RegWrite, mem_w, ALU_Control, CPU_MIO}
  function automatic logic [12:0] packOut();
    return {RegDst, ALUSrc_B, DatatoReg, Jal, Branch, RegWrite, mem_w, ALU_Control, CPU_MIO};
  endfunction

  localparam logic [5:0] R_FUNS [0:8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h02, 6'h26, 6'h16};
  localparam logic [2:0] R_ALU  [0:8] = '{3'd2, 3'd6, 3'd0, 3'd1, 3'd7, 3'd4, 3'd5, 3'd3, 3'd3};
  localparam logic [5:0] I_OPS  [0:4] = '{6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e};
  localparam logic [2:0] I_ALU  [0:4] = '{3'd2, 3'd7, 3'd0, 3'd1, 3'd3};

  // Instruction-class model: each output is a predicate over the instruction class.
  function automatic logic [12:0] model(input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic isR, rHit, iHit, isJr, isLw, isSw, isBeq, isBne, isJ, isJal, isLui;
    logic [2:0] rCode, iCode, alu;
    logic [1:0] dtr, br;
    rHit = 1'b0; iHit = 1'b0; rCode = 3'd0; iCode = 3'd0;
    isR = (op == 6'h00);
    for (int k = 0; k < 9; k++)
      if (isR && fn == R_FUNS[k]) begin rHit = 1'b1; rCode = R_ALU[k]; end
    for (int k = 0; k < 5; k++)
      if (op == I_OPS[k]) begin iHit = 1'b1; iCode = I_ALU[k]; end
    isJr  = isR && (fn == 6'h08);
    isLw  = (op == 6'h23);
    isSw  = (op == 6'h2b);
    isBeq = (op == 6'h04);
    isBne = (op == 6'h05);
    isJ   = (op == 6'h02);
    isJal = (op == 6'h03);
    isLui = (op == 6'h0f);
    dtr = isLw ? 2'd1 : isJal ? 2'd2 : isLui ? 2'd3 : 2'd0;
    br  = isJr ? 2'd3 : (isJ || isJal) ? 2'd2 : ((isBeq && z) || (isBne && !z)) ? 2'd1 : 2'd0;
    alu = rHit ? rCode : iHit ? iCode : (isBeq || isBne) ? 3'd6 : 3'd2;
    return {rHit, (isLw || isSw || iHit || isLui), dtr, isJal, br,
            (rHit || isLw || isJal || iHit || isLui), isSw, alu, (isLw || isSw)};
  endfunction

  logic [12:0] expQ;
  logic        expValid = 1'b0;

  always @(posedge clk) begin
    expQ     <= rst ? 13'd0 : model(OPcode, Fun, zero);
    expValid <= 1'b1;
  end

  // Per-cycle comparison against the model, plus the mutual-exclusion invariants.
  always @(negedge clk) begin
    if (expValid) begin
      total++;
      if (packOut() !== expQ) begin
        bad++;
        $display("[TB] FAIL model_cmp t=%0t got=%b want=%b", $time, packOut(), expQ);
      end
      total++;
      if ((mem_w && RegWrite) || (mem_w && Branch != 2'b00)) begin
        bad++;
        $display("[TB] FAIL exclusivity t=%0t mem_w=%b RegWrite=%b Branch=%b", $time, mem_w, RegWrite, Branch);
      end
    end
  end

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic r);
    OPcode    = op;
    Fun       = fn;
    zero      = z;
    rst       = r;
    MIO_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [12:0] want);
    total++;
    if (packOut() !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%b want=%b", name, packOut(), want);
    end
  endtask

  initial begin
    OPcode = 6'h00; Fun = 6'h00; zero = 1'b0; rst = 1'b1; MIO_ready = 1'b0;
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b1);
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b1);
    checkOutput("reset_with_lw", 13'b0_0_00_0_00_0_0_000_0);
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b0);
    checkOutput("lw_after_reset", 13'b0_1_01_0_00_1_0_010_1);

    applyStimulus(6'h00, 6'h20, 1'b0, 1'b0);
    checkOutput("r_add", 13'b1_0_00_0_00_1_0_010_0);
    applyStimulus(6'h00, 6'h22, 1'b0, 1'b0);
    checkOutput("r_sub", 13'b1_0_00_0_00_1_0_110_0);
    applyStimulus(6'h00, 6'h24, 1'b0, 1'b0);
    checkOutput("r_and", 13'b1_0_00_0_00_1_0_000_0);
    applyStimulus(6'h00, 6'h25, 1'b0, 1'b0);
    checkOutput("r_or", 13'b1_0_00_0_00_1_0_001_0);
    applyStimulus(6'h00, 6'h2a, 1'b0, 1'b0);
    checkOutput("r_slt", 13'b1_0_00_0_00_1_0_111_0);
    applyStimulus(6'h00, 6'h27, 1'b0, 1'b0);
    checkOutput("r_nor", 13'b1_0_00_0_00_1_0_100_0);
    applyStimulus(6'h00, 6'h02, 1'b0, 1'b0);
    checkOutput("r_srl", 13'b1_0_00_0_00_1_0_101_0);
    applyStimulus(6'h00, 6'h16, 1'b0, 1'b0);
    checkOutput("r_xor_alt", 13'b1_0_00_0_00_1_0_011_0);
    applyStimulus(6'h00, 6'h08, 1'b0, 1'b0);
    checkOutput("r_jr", 13'b0_0_00_0_11_0_0_010_0);
    applyStimulus(6'h00, 6'h3f, 1'b0, 1'b0);
    checkOutput("r_unknown", 13'b0_0_00_0_00_0_0_010_0);

    applyStimulus(6'h04, 6'h00, 1'b1, 1'b0);
    checkOutput("beq_taken", 13'b0_0_00_0_01_0_0_110_0);
    applyStimulus(6'h04, 6'h00, 1'b0, 1'b0);
    checkOutput("beq_not_taken", 13'b0_0_00_0_00_0_0_110_0);
    applyStimulus(6'h05, 6'h00, 1'b0, 1'b0);
    checkOutput("bne_taken", 13'b0_0_00_0_01_0_0_110_0);
    applyStimulus(6'h05, 6'h00, 1'b1, 1'b0);
    checkOutput("bne_not_taken", 13'b0_0_00_0_00_0_0_110_0);

    applyStimulus(6'h2b, 6'h00, 1'b0, 1'b0);
    checkOutput("sw", 13'b0_1_00_0_00_0_1_010_1);
    applyStimulus(6'h03, 6'h00, 1'b0, 1'b0);
    checkOutput("jal", 13'b0_0_10_1_10_1_0_010_0);
    applyStimulus(6'h02, 6'h00, 1'b0, 1'b0);
    checkOutput("j", 13'b0_0_00_0_10_0_0_010_0);
    applyStimulus(6'h0a, 6'h00, 1'b0, 1'b0);
    checkOutput("slti", 13'b0_1_00_0_00_1_0_111_0);
    applyStimulus(6'h0d, 6'h00, 1'b0, 1'b0);
    checkOutput("ori", 13'b0_1_00_0_00_1_0_001_0);
    applyStimulus(6'h0f, 6'h00, 1'b0, 1'b0);
    checkOutput("lui", 13'b0_1_11_0_00_1_0_010_0);
    applyStimulus(6'h3f, 6'h20, 1'b1, 1'b0);
    checkOutput("undefined_op", 13'b0_0_00_0_00_0_0_010_0);

    applyStimulus(6'h03, 6'h00, 1'b0, 1'b1);
    checkOutput("mid_reset_jal", 13'b0_0_00_0_00_0_0_000_0);
    applyStimulus(6'h0e, 6'h00, 1'b0, 1'b0);
    checkOutput("xori_after_reset", 13'b0_1_00_0_00_1_0_011_0);

    for (int n = 0; n < 60; n++)
      applyStimulus(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                    1'($urandom_range(0, 1)), (($urandom_range(0, 15)) == 0));

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
